// File: rtl/usb_rx_packet_ctrl_if.sv
// Output stream of usb_rx_packet_ctrl: payload bytes, packet status pulses and error code.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer stalls the byte stream.
interface usb_rx_packet_ctrl_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [3:0] out_pid;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       overrun;

    // Packet controller side
    modport master (
        output out_data, out_valid, out_last, out_pid,
        output pkt_done, pkt_err, err_code, overrun,
        input  out_ready
    );

    // Downstream consumer side
    modport slave (
        input  out_data, out_valid, out_last, out_pid,
        input  pkt_done, pkt_err, err_code, overrun,
        output out_ready
    );
endinterface

// File: rtl/usb_rx_packet_ctrl.sv
// Captures a USB_reader packet on EOP, checks PID and CRC16, then streams the payload bytes (macro USB_RX_CRC_CHECK_EN enables CRC).
// Latency: 67 cycles from detected EOP edge to first out_valid with CRC checking, 3 cycles without.
// Backpressure: output byte held while out_valid & ~out_ready; an EOP arriving while busy is dropped and pulses overrun.
module usb_rx_packet_ctrl #(
    parameter int PAYLOAD_BYTES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 PID_data,
    input  logic [PAYLOAD_BYTES*8-1:0] data,
    input  logic [15:0]                CRC_data,
    input  logic                       EOP_found,
    usb_rx_packet_ctrl_if.master       out_if
);
    localparam int DATA_W = PAYLOAD_BYTES * 8;
    localparam int IDX_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CAPTURE, ST_CRC, ST_CHECK, ST_SEND, ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              eop_q, eop_d;
    logic              edge_q, edge_d;
    logic [7:0]        pid_q, pid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              pkt_done_q, pkt_done_d;
    logic              pkt_err_q, pkt_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              overrun_q, overrun_d;

    logic              capture;
    logic              crc_done;
    logic              crc_ok;
    logic              pid_ok;
    logic [DATA_W-1:0] next_bytes;

    assign capture = (state_q == ST_IDLE) && edge_q;
    assign pid_ok  = (pid_q[7:4] == ~pid_q[3:0]);

`ifdef USB_RX_CRC_CHECK_EN
    localparam int CNT_W = $clog2(DATA_W);

    logic [15:0]       crc_q, crc_d;
    logic [15:0]       crc_rx_q, crc_rx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] crc_shift;
    logic              fb;

    // Bit-serial CRC16 over the shadow payload, first received bit first
    always_comb begin
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        crc_rx_d  = crc_rx_q;
        crc_shift = data_q << cnt_q;
        fb        = crc_shift[DATA_W-1] ^ crc_q[15];
        if (capture) begin
            crc_rx_d = CRC_data;
        end
        if (state_q == ST_CAPTURE) begin
            crc_d = 16'hFFFF;
            cnt_d = '0;
        end else if (state_q == ST_CRC) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign crc_done = (state_q == ST_CRC) && (cnt_q == CNT_W'(DATA_W - 1));
    assign crc_ok   = (~crc_q == crc_rx_q);

    // CRC engine registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q    <= 16'hFFFF;
            crc_rx_q <= '0;
            cnt_q    <= '0;
        end else begin
            crc_q    <= crc_d;
            crc_rx_q <= crc_rx_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    logic crc_unused;
    assign crc_unused = ^CRC_data;
    assign crc_done   = 1'b0;
    assign crc_ok     = 1'b1;
`endif

    // Packet sequencing: capture, check, stream bytes, report status
    always_comb begin
        state_d     = state_q;
        eop_d       = EOP_found;
        edge_d      = EOP_found & ~eop_q;
        pid_d       = pid_q;
        data_d      = data_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;
        overrun_d   = edge_q && (state_q != ST_IDLE);
        next_bytes  = data_q << {idx_q + 1'b1, 3'b000};

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    pid_d      = PID_data;
                    data_d     = data;
                    err_code_d = 2'b00;
                    state_d    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
`ifdef USB_RX_CRC_CHECK_EN
                state_d = ST_CRC;
`else
                state_d = ST_CHECK;
`endif
            end
            ST_CRC: begin
                if (crc_done) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (pid_ok && crc_ok) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = data_q[DATA_W-1 -: 8];
                    out_last_d  = (PAYLOAD_BYTES == 1);
                    state_d     = ST_SEND;
                end else begin
                    pkt_err_d  = 1'b1;
                    err_code_d = {~crc_ok, ~pid_ok};
                    state_d    = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_valid_q && out_if.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        pkt_done_d  = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        out_data_d = next_bytes[DATA_W-1 -: 8];
                        out_last_d = ((idx_q + 1'b1) == IDX_W'(PAYLOAD_BYTES - 1));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control, shadow and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            eop_q       <= 1'b0;
            edge_q      <= 1'b0;
            pid_q       <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= 2'b00;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            eop_q       <= eop_d;
            edge_q      <= edge_d;
            pid_q       <= pid_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
            err_code_q  <= err_code_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign out_if.out_pid   = pid_q[3:0];
    assign out_if.pkt_done  = pkt_done_q;
    assign out_if.pkt_err   = pkt_err_q;
    assign out_if.err_code  = err_code_q;
    assign out_if.overrun   = overrun_q;
endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Scoreboard bench for usb_rx_packet_ctrl: reference model predicts bytes/status, monitor compares.
// Latency: checks 67/3-cycle EOP-to-first-byte and the 8-cycle burst under constant ready.
// Backpressure: out_ready driven constant, 1-0-0 pattern or random; stalled bytes must hold.
module tb_usb_rx_packet_ctrl;
`ifdef USB_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    // Cycles from driving EOP high until out_valid / pkt_err is visible
    localparam int LAT = CRC_EN ? 68 : 4;

    typedef struct {
        int         kind;   // 0 byte, 1 pkt_done, 2 pkt_err
        logic [7:0] dat;
        logic       last;
        logic [3:0] pid;
        logic [1:0] code;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pid = '0;
    logic [63:0] dat = '0;
    logic [15:0] crc = '0;
    logic        eop = 1'b0;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  xfer_cnt = 0;
    int  end_cnt = 0;
    int  ovr_seen = 0;
    int  exp_ovr = 0;
    int  ready_mode = 0;

    always #5 clk = ~clk;

    usb_rx_packet_ctrl_if ifc ();

    usb_rx_packet_ctrl #(.PAYLOAD_BYTES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .PID_data  (pid),
        .data      (dat),
        .CRC_data  (crc),
        .EOP_found (eop),
        .out_if    (ifc.master)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] golden_crc(input logic [63:0] d);
        logic [15:0] c = 16'hFFFF;
        for (int i = 63; i >= 0; i--) begin
            if ((d[i] ^ c[15]) == 1'b1) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                        c = {c[14:0], 1'b0};
        end
        return ~c;
    endfunction

    // Reference model: what the consumer should see for one packet
    task automatic expect_pkt(input logic [7:0] p, input logic [63:0] d, input logic [15:0] c);
        logic pid_bad, crc_bad;
        ev_t  e;
        pid_bad = (p[7:4] != ~p[3:0]);
        crc_bad = CRC_EN && (c != golden_crc(d));
        e.pid = p[3:0];
        e.code = 2'b00;
        if (!pid_bad && !crc_bad) begin
            for (int i = 0; i < 8; i++) begin
                e.kind = 0;
                e.dat  = 8'(d >> (8 * (7 - i)));
                e.last = (i == 7);
                exp_q.push_back(e);
            end
            e.kind = 1; e.dat = '0; e.last = 1'b0;
            exp_q.push_back(e);
        end else begin
            e.kind = 2; e.dat = '0; e.last = 1'b0;
            e.code = {crc_bad, pid_bad};
            exp_q.push_back(e);
        end
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got event kind %0d, required none", kind);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == 0 && e.kind == 0) begin
                check("byte_data", ifc.out_data, e.dat);
                check("byte_last", ifc.out_last, e.last);
                check("out_pid", ifc.out_pid, e.pid);
            end
            if (kind == 2 && e.kind == 2) begin
                check("err_code", ifc.err_code, e.code);
            end
        end
    endtask

    // Monitor: sample on the falling edge and compare against the scoreboard
    initial begin
        logic       stall_prev = 1'b0;
        logic [8:0] prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_hold_valid", ifc.out_valid, 1'b1);
                    check("stall_hold_byte", {ifc.out_last, ifc.out_data}, prev);
                end
                if (ifc.out_valid && ifc.out_ready) begin
                    pop_check(0);
                    xfer_cnt++;
                end
                if (ifc.pkt_done) begin
                    pop_check(1);
                    end_cnt++;
                end
                if (ifc.pkt_err) begin
                    pop_check(2);
                    end_cnt++;
                end
                if (ifc.overrun) ovr_seen++;
                stall_prev = ifc.out_valid && !ifc.out_ready;
                prev = {ifc.out_last, ifc.out_data};
            end
        end
    end

    // Consumer ready: 0 constant, 1 pattern 1,0,0,..., 2 random
    initial begin
        int ph = 0;
        ifc.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       ifc.out_ready = 1'b1;
                1:       ifc.out_ready = ((ph % 3) == 0);
                default: ifc.out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string name);
        check(name, {ifc.out_data, ifc.out_valid, ifc.out_last, ifc.out_pid,
                     ifc.pkt_done, ifc.pkt_err, ifc.err_code, ifc.overrun}, 64'd0);
    endtask

    task automatic send_pkt(input logic [7:0] p, input logic [63:0] d, input logic [15:0] c,
                            input int rmode, input int ovr_at, input int eop_len);
        int start, lat, first_v, done_at, cyc;
        logic good;
        good = (p[7:4] == ~p[3:0]) && (!CRC_EN || c == golden_crc(d));
        expect_pkt(p, d, c);
        if (ovr_at > 0) exp_ovr++;
        ready_mode = rmode;
        @(posedge clk); #1;
        pid = p; dat = d; crc = c; eop = 1'b1;
        start = end_cnt; lat = -1; first_v = -1; done_at = -1; cyc = 0;
        while (end_cnt == start && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == eop_len) eop = 1'b0;
            if (cyc == ovr_at) begin eop = 1'b1; pid = ~p; dat = ~d; end
            if (cyc == ovr_at + 2) eop = 1'b0;
            if (lat < 0 && (ifc.out_valid || ifc.pkt_err)) lat = cyc;
            if (first_v < 0 && ifc.out_valid) first_v = cyc;
            if (ifc.pkt_done) done_at = cyc;
        end
        eop = 1'b0;
        if (end_cnt == start) begin
            n_checks++;
            n_fail++;
            $display("FAIL pkt_timeout: no pkt_done/pkt_err after %0d cycles, required one", cyc);
        end
        check("latency", lat, LAT);
        if (good && rmode == 0) check("done_gap", done_at - first_v, 8);
        repeat (3) @(posedge clk);
    endtask

    task automatic reset_mid_send(input logic [7:0] p, input logic [63:0] d);
        int start, cyc;
        expect_pkt(p, d, golden_crc(d));
        ready_mode = 0;
        @(posedge clk); #1;
        pid = p; dat = d; crc = golden_crc(d); eop = 1'b1;
        repeat (3) @(posedge clk);
        #1 eop = 1'b0;
        start = xfer_cnt; cyc = 0;
        while (xfer_cnt - start < 3 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        check("bytes_before_reset", xfer_cnt - start, 3);
        #1 rst = 1'b1;
        #1 check_all_zero("reset_mid_send_outputs");
        exp_q.delete();
        @(posedge clk); #1;
        check_all_zero("reset_held_outputs");
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [63:0] d0;
        logic [15:0] g0;
        d0 = 64'h00FF77BB33DD5599;
        g0 = golden_crc(d0);

        #2 check_all_zero("reset_outputs_async");
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_outputs_held");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("idle_outputs");

        send_pkt(8'hC3, d0, g0, 0, 0, 3);
        send_pkt(8'hC3, d0, g0 ^ 16'h0001, 0, 0, 3);
        send_pkt(8'hC4, d0, g0, 0, 0, 3);
        send_pkt(8'hC4, d0, g0 ^ 16'h0001, 0, 0, 3);
        send_pkt(8'hC3, d0, g0, 1, 0, 3);
        send_pkt(8'hE1, 64'h0123456789ABCDEF, golden_crc(64'h0123456789ABCDEF), 1, 10, 3);
        send_pkt(8'h5A, 64'hFEDCBA9876543210, golden_crc(64'hFEDCBA9876543210), 1, LAT + 2, 3);
        send_pkt(8'hD2, 64'h1122334455667788, golden_crc(64'h1122334455667788), 0, 0, 1000);

        reset_mid_send(8'hC3, d0);
        send_pkt(8'h96, 64'hA5A5A5A55A5A5A5A, golden_crc(64'hA5A5A5A55A5A5A5A), 0, 0, 3);

        for (int n = 0; n < 20; n++) begin
            logic [7:0]  p;
            logic [63:0] d;
            logic [15:0] c;
            logic [3:0]  nib;
            nib = 4'($urandom_range(0, 15));
            p = ($urandom_range(0, 3) != 0) ? {~nib, nib} : 8'($urandom);
            d = {$urandom, $urandom};
            c = golden_crc(d);
            if ($urandom_range(0, 3) == 0) c = c ^ (16'h0001 << $urandom_range(0, 15));
            send_pkt(p, d, c, 2, 0, 1 + $urandom_range(0, 4));
        end

        check("overrun_count", ovr_seen, exp_ovr);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
